div_clk_monitor: RTL and testbench
==================================

Name: div_clk_monitor

Overview:
- Downstream checker for the odd/even clock divider output; runs on the divider's source clock `clk`.
- Samples the divided clock, measures its period and high time in `clk` cycles, and compares both against the programmed ratio.
- Reports lock, period, duty and stuck-clock errors to the clock-control status registers.
- Gives bring-up and BIST a way to confirm that the divider produces N-cycle, ~50% duty output.

Parameters:
- RATIO_W, 8, width of the divide ratio and of the measurement counters' compare value.
- CNT_W, 10, width of the period/high counters; must be at least RATIO_W+2.
- SYNC_STAGES, 2, synchronizer flops on clk_div_in (minimum 2).
- LOCK_CNT, 4, consecutive good periods required to assert lock.
- PER_TOL, 0, allowed |period_meas - N| in clk cycles.

Ports:
- clk  in  1  source clock of the divider; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  monitor enable; deassert returns to IDLE.
- div_ratio  in  RATIO_W  expected divide ratio N; captured on the IDLE->SYNC transition.
- clk_div_in  in  1  divided clock under test (asynchronous to the sampling phase).
- err_clear  in  1  single-cycle pulse; clears sticky errors.
- lock  out  1  divided clock verified.
- period_err  out  1  sticky: a measured period was outside tolerance.
- duty_err  out  1  sticky: a measured high time was outside tolerance.
- stuck_err  out  1  sticky: no rising edge seen within 2N cycles.
- cfg_err  out  1  level: captured N < 2.
- period_meas  out  CNT_W  last completed period measurement.
- high_meas  out  CNT_W  last completed high-time measurement.

Behaviour:
- **Reset.** All outputs are 0, FSM is IDLE, counters are 0 and synchronizer flops are 0.
- **Sampling.** s = clk_div_in after SYNC_STAGES flops.
  - s_d = s delayed one cycle.
  - rise = s & ~s_d, so rise is seen SYNC_STAGES+1 cycles after the physical edge.
- **FSM states:** IDLE, SYNC, MEASURE, LOCKED.
  - IDLE: when enable=1, capture N=div_ratio.
    - If N<2, set cfg_err and stay in IDLE.
    - Otherwise clear cfg_err and go to SYNC.
  - SYNC: wait for the first rise. On rise, clear the counters and go to MEASURE; good_cnt=0.
  - MEASURE and LOCKED: counters run, and each rise completes a measurement.
- **Counters.**
  - per_cnt: cleared to 1 on rise, otherwise per_cnt+1, saturating at all-ones.
  - hi_cnt: on rise it is loaded with 1, because s=1 on the rise cycle. Otherwise it increments when s=1, and also saturates.
- **On each rise in MEASURE/LOCKED:**
  - Load period_meas=per_cnt and high_meas=hi_cnt, then restart both counters.
  - The period is good iff |period_meas - N| <= PER_TOL.
  - The duty is good iff |2*high_meas - N| <= 1. For odd N this allows high of (N-1)/2 or (N+1)/2; for even N, high must be exactly N/2.
  - Compute the differences in CNT_W+2 bits, signed.
- **Good measurement (period and duty both good).**
  - good_cnt increments, saturating at LOCK_CNT.
  - When it reaches LOCK_CNT: go to LOCKED and set lock=1 in the same cycle the outputs register.
- **Bad measurement.**
  - Set the corresponding sticky error(s).
  - good_cnt=0 and lock=0; the FSM goes to MEASURE from either state.
- **Timeout.** If per_cnt reaches 2N with no rise (in SYNC, MEASURE or LOCKED):
  - Set stuck_err and lock=0.
  - Go to SYNC with the counters cleared.
- **Enable deassert.** From any state: go to IDLE next cycle, lock=0. Sticky errors and meas registers hold.
- **err_clear.** Clears period_err, duty_err and stuck_err.
  - If an error event occurs in the same cycle, the set wins.
  - cfg_err is not sticky; it is re-evaluated at each capture.
- **div_ratio changes while enabled are ignored.** Software must toggle enable to re-capture.
- **Async reset mid-measurement.** Immediate return to reset values; no partial measurement is reported.

Decomposition:
- Shared clk_ctrl package:
  - FSM state enum (IDLE, SYNC, MEASURE, LOCKED).
  - Default widths RATIO_W/CNT_W.
  - Localparam for the minimum legal ratio (2).
- One natural sub-module: `sync_rise_det`, which is the SYNC_STAGES synchronizer plus the rise pulse and the s level output.
- Counters, checks and FSM stay in the top module.

Test Plan:
- **Clean N=3.** Drive clk_div_in from the divider with N=3, enable=1 → period_meas=3, high_meas of 1 or 2, lock=1 after the 4th good rise, no errors.
- **Clean N=4.** Drive an ideal 50% divide-by-4 → high_meas=2, period_meas=4, lock=1; then force high=3 for one period → duty_err=1, lock=0, relock after 4 more good periods.
- **Period error.** N=5, inject a single 6-cycle period while LOCKED → period_meas=6, period_err=1, lock drops the cycle after the capture, FSM in MEASURE.
- **Stuck clock.** N=7, hold clk_div_in=0 after lock → stuck_err=1 at 14 cycles after the last rise, lock=0, FSM in SYNC; restart the clock → relock.
- **Configuration error.** div_ratio=1, enable=1 → cfg_err=1, FSM in IDLE, lock=0; then deassert enable, set div_ratio=3, re-enable → cfg_err=0 and normal lock.
- **Clear vs. set, and reset.** err_clear pulsed in the same cycle as a new period error → period_err stays 1. Assert rst low mid-period → all outputs 0 immediately.

Source files
------------

// File: rtl/div_clk_monitor_pkg.sv
// Shared clock-control definitions for the divided-clock monitor.
// Contents:
//   - state_t     : monitor FSM states (IDLE, SYNC, MEASURE, LOCKED)
//   - RATIO_W_DEF : default divide-ratio width
//   - CNT_W_DEF   : default measurement counter width
//   - MIN_RATIO   : smallest divide ratio the divider can produce
package div_clk_monitor_pkg;

  localparam int RATIO_W_DEF = 8;
  localparam int CNT_W_DEF   = 10;
  localparam int MIN_RATIO   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    MEASURE = 2'd2,
    LOCKED  = 2'd3
  } state_t;

endpackage

// File: rtl/div_clk_monitor_sync_rise_det.sv
// sync_rise_det: synchronizer for the divided clock plus rising-edge pulse.
// Ports:
//   clk  in  sampling clock
//   rst  in  asynchronous active-low reset
//   din  in  asynchronous divided clock
//   s    out synchronized level (after SYNC_STAGES flops)
//   rise out single-cycle pulse, s & ~s_delayed
module sync_rise_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s_d_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg <= '0;
      s_d_reg  <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
      s_d_reg  <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign s    = sync_reg[SYNC_STAGES-1];
  assign rise = s & ~s_d_reg;

endmodule

// File: rtl/div_clk_monitor.sv
// div_clk_monitor: checks that the divided clock has period N and ~50% duty.
// Ports:
//   clk, rst         source clock of the divider; async active-low reset
//   enable           run the monitor; low returns to IDLE
//   div_ratio        expected ratio N, captured when leaving IDLE
//   clk_div_in       divided clock under test
//   err_clear        pulse clearing the sticky errors
//   lock             divided clock verified (LOCK_CNT good periods in a row)
//   period_err       sticky, period outside tolerance
//   duty_err         sticky, high time outside tolerance
//   stuck_err        sticky, no rising edge within 2N cycles
//   cfg_err          captured N below the minimum ratio
//   period_meas      last completed period measurement
//   high_meas        last completed high-time measurement
module div_clk_monitor
  import div_clk_monitor_pkg::*;
#(
  parameter int RATIO_W     = RATIO_W_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CNT    = 4,
  parameter int PER_TOL     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [RATIO_W-1:0] div_ratio,
  input  logic               clk_div_in,
  input  logic               err_clear,
  output logic               lock,
  output logic               period_err,
  output logic               duty_err,
  output logic               stuck_err,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   period_meas,
  output logic [CNT_W-1:0]   high_meas
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int DW = CNT_W + 2;

  logic s, rise;

  sync_rise_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (clk_div_in),
    .s    (s),
    .rise (rise)
  );

  state_t             state_reg;
  logic [RATIO_W-1:0] n_reg;
  logic [CNT_W-1:0]   per_cnt_reg, hi_cnt_reg;
  logic [GW-1:0]      good_cnt_reg;
  // Set after a bad capture so IDLE does not keep re-capturing while
  // enable stays high; software has to drop enable to try again.
  logic               cfg_block_reg;
  logic               lock_reg, period_err_reg, duty_err_reg, stuck_err_reg, cfg_err_reg;
  logic [CNT_W-1:0]   period_meas_reg, high_meas_reg;

  logic signed [DW-1:0] per_diff, duty_diff;
  logic [DW-1:0]        per_abs, duty_abs;
  logic                 per_ok, duty_ok, timeout;
  logic [CNT_W-1:0]     per_inc, hi_inc, limit;
  logic [GW-1:0]        good_sat;

  always_comb begin
    per_diff  = $signed({2'b00, per_cnt_reg}) - $signed(DW'(n_reg));
    duty_diff = $signed({1'b0, hi_cnt_reg, 1'b0}) - $signed(DW'(n_reg));
    per_abs   = per_diff[DW-1] ? -per_diff : per_diff;
    duty_abs  = duty_diff[DW-1] ? -duty_diff : duty_diff;
    per_ok    = (per_abs <= DW'(PER_TOL));
    duty_ok   = (duty_abs <= DW'(1));
    limit     = CNT_W'({n_reg, 1'b0});
    timeout   = (per_cnt_reg == limit);
    per_inc   = (per_cnt_reg == '1) ? per_cnt_reg : per_cnt_reg + CNT_W'(1);
    hi_inc    = (s && hi_cnt_reg != '1) ? hi_cnt_reg + CNT_W'(1) : hi_cnt_reg;
    good_sat  = (good_cnt_reg >= GW'(LOCK_CNT)) ? GW'(LOCK_CNT) : good_cnt_reg + GW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      n_reg           <= '0;
      per_cnt_reg     <= '0;
      hi_cnt_reg      <= '0;
      good_cnt_reg    <= '0;
      cfg_block_reg   <= 1'b0;
      lock_reg        <= 1'b0;
      period_err_reg  <= 1'b0;
      duty_err_reg    <= 1'b0;
      stuck_err_reg   <= 1'b0;
      cfg_err_reg     <= 1'b0;
      period_meas_reg <= '0;
      high_meas_reg   <= '0;
    end else begin
      // Clear first; any error set later in this block overrides it.
      if (err_clear) begin
        period_err_reg <= 1'b0;
        duty_err_reg   <= 1'b0;
        stuck_err_reg  <= 1'b0;
      end

      if (!enable) begin
        state_reg     <= IDLE;
        lock_reg      <= 1'b0;
        cfg_block_reg <= 1'b0;
        per_cnt_reg   <= '0;
        hi_cnt_reg    <= '0;
        good_cnt_reg  <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (!cfg_block_reg) begin
              n_reg        <= div_ratio;
              per_cnt_reg  <= '0;
              hi_cnt_reg   <= '0;
              good_cnt_reg <= '0;
              if (div_ratio < RATIO_W'(MIN_RATIO)) begin
                cfg_err_reg   <= 1'b1;
                cfg_block_reg <= 1'b1;
              end else begin
                cfg_err_reg <= 1'b0;
                state_reg   <= SYNC;
              end
            end
          end

          SYNC: begin
            if (rise) begin
              // s is already high on the rise cycle, so both restart at 1.
              per_cnt_reg  <= CNT_W'(1);
              hi_cnt_reg   <= CNT_W'(1);
              good_cnt_reg <= '0;
              state_reg    <= MEASURE;
            end else if (timeout) begin
              stuck_err_reg <= 1'b1;
              per_cnt_reg   <= '0;
              hi_cnt_reg    <= '0;
            end else begin
              per_cnt_reg <= per_inc;
              hi_cnt_reg  <= hi_inc;
            end
          end

          MEASURE, LOCKED: begin
            if (rise) begin
              period_meas_reg <= per_cnt_reg;
              high_meas_reg   <= hi_cnt_reg;
              per_cnt_reg     <= CNT_W'(1);
              hi_cnt_reg      <= CNT_W'(1);
              if (per_ok && duty_ok) begin
                good_cnt_reg <= good_sat;
                if (good_sat == GW'(LOCK_CNT)) begin
                  state_reg <= LOCKED;
                  lock_reg  <= 1'b1;
                end
              end else begin
                if (!per_ok)  period_err_reg <= 1'b1;
                if (!duty_ok) duty_err_reg   <= 1'b1;
                good_cnt_reg <= '0;
                lock_reg     <= 1'b0;
                state_reg    <= MEASURE;
              end
            end else if (timeout) begin
              stuck_err_reg <= 1'b1;
              lock_reg      <= 1'b0;
              good_cnt_reg  <= '0;
              per_cnt_reg   <= '0;
              hi_cnt_reg    <= '0;
              state_reg     <= SYNC;
            end else begin
              per_cnt_reg <= per_inc;
              hi_cnt_reg  <= hi_inc;
            end
          end

          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign lock        = lock_reg;
  assign period_err  = period_err_reg;
  assign duty_err    = duty_err_reg;
  assign stuck_err   = stuck_err_reg;
  assign cfg_err     = cfg_err_reg;
  assign period_meas = period_meas_reg;
  assign high_meas   = high_meas_reg;

endmodule

// File: tb/tb_div_clk_monitor.sv
// Directed bench for div_clk_monitor. The divided clock is driven one
// clk cycle at a time from the falling edge; expected values are worked
// out by hand from the period/high pattern being driven.
module tb_div_clk_monitor;
  import div_clk_monitor_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] div_ratio = 8'd0;
  logic       clk_div_in = 1'b0;
  logic       err_clear = 1'b0;
  logic       lock, period_err, duty_err, stuck_err, cfg_err;
  logic [9:0] period_meas, high_meas;

  int errors = 0;
  int checks = 0;

  div_clk_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .div_ratio   (div_ratio),
    .clk_div_in  (clk_div_in),
    .err_clear   (err_clear),
    .lock        (lock),
    .period_err  (period_err),
    .duty_err    (duty_err),
    .stuck_err   (stuck_err),
    .cfg_err     (cfg_err),
    .period_meas (period_meas),
    .high_meas   (high_meas)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // n periods of length per with hi high cycles; err_clear pulses on
  // cycle clr_at of every period (-1 for none). The rise of each period
  // is processed on its third clk edge, so all n rises are seen on return.
  task automatic drive(input int n, input int per, input int hi, input int clr_at);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < per; i++) begin
        clk_div_in = (i < hi);
        err_clear  = (i == clr_at);
        @(negedge clk);
      end
    end
    err_clear = 1'b0;
    $display("drive: %0d periods of %0d (high %0d) lock=%0d pm=%0d hm=%0d",
             n, per, hi, lock, period_meas, high_meas);
  endtask

  task automatic hold_low(input int n);
    clk_div_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Drop enable for one cycle (also clearing sticky errors), then
  // re-enable with a new ratio and let the capture happen.
  task automatic restart(input int ratio);
    clk_div_in = 1'b0;
    enable     = 1'b0;
    err_clear  = 1'b1;
    @(negedge clk);
    err_clear  = 1'b0;
    div_ratio  = 8'(ratio);
    enable     = 1'b1;
    repeat (2) @(negedge clk);
    $display("restart: ratio=%0d cfg_err=%0d", ratio, cfg_err);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_lock", lock, 0);
    chk("rst_perr", period_err, 0);
    chk("rst_derr", duty_err, 0);
    chk("rst_serr", stuck_err, 0);
    chk("rst_cerr", cfg_err, 0);
    chk("rst_pm", period_meas, 0);
    chk("rst_hm", high_meas, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Clean N=3: first rise syncs, four good measurements lock
    restart(3);
    chk("n3_state_sync", dut.state_reg, SYNC);
    drive(4, 3, 1, -1);
    chk("n3_lock_early", lock, 0);
    drive(1, 3, 1, -1);
    chk("n3_lock", lock, 1);
    chk("n3_pm", period_meas, 3);
    chk("n3_hm", high_meas, 1);
    drive(2, 3, 2, -1);
    chk("n3_hm_hi2", high_meas, 2);
    chk("n3_lock_hi2", lock, 1);
    chk("n3_noerr", {period_err, duty_err, stuck_err, cfg_err}, 0);

    // Clean N=4, then one 3-high period breaks duty
    restart(4);
    drive(5, 4, 2, -1);
    chk("n4_lock", lock, 1);
    chk("n4_pm", period_meas, 4);
    chk("n4_hm", high_meas, 2);
    drive(1, 4, 3, -1);
    drive(1, 4, 2, -1);
    chk("n4_derr", duty_err, 1);
    chk("n4_hm_bad", high_meas, 3);
    chk("n4_lock_drop", lock, 0);
    chk("n4_perr_clean", period_err, 0);
    drive(3, 4, 2, -1);
    chk("n4_relock_early", lock, 0);
    drive(1, 4, 2, -1);
    chk("n4_relock", lock, 1);

    // Period error N=5
    restart(5);
    chk("n5_cleared", duty_err, 0);
    drive(5, 5, 2, -1);
    chk("n5_lock", lock, 1);
    drive(1, 6, 2, -1);
    drive(1, 5, 2, -1);
    chk("n5_pm", period_meas, 6);
    chk("n5_perr", period_err, 1);
    chk("n5_derr", duty_err, 0);
    chk("n5_lock_drop", lock, 0);
    chk("n5_state", dut.state_reg, MEASURE);

    // Stuck clock N=7: timeout lands 14 cycles after the last rise
    restart(7);
    drive(5, 7, 3, -1);
    chk("n7_lock", lock, 1);
    hold_low(9);
    chk("n7_stuck_early", stuck_err, 0);
    hold_low(1);
    chk("n7_stuck", stuck_err, 1);
    chk("n7_lock_drop", lock, 0);
    chk("n7_state", dut.state_reg, SYNC);
    drive(5, 7, 3, -1);
    chk("n7_relock", lock, 1);

    // Configuration error, then recovery
    restart(1);
    chk("cfg_err", cfg_err, 1);
    chk("cfg_state", dut.state_reg, IDLE);
    chk("cfg_lock", lock, 0);
    restart(3);
    chk("cfg_ok", cfg_err, 0);
    chk("cfg_state_sync", dut.state_reg, SYNC);
    drive(5, 3, 1, -1);
    chk("cfg_relock", lock, 1);

    // err_clear in the same cycle as a new period error: set wins
    drive(1, 4, 1, -1);
    chk("clr_pre", period_err, 0);
    drive(1, 3, 1, 2);
    chk("clr_set_wins", period_err, 1);
    chk("clr_pm", period_meas, 4);
    chk("clr_lock", lock, 0);
    drive(1, 3, 1, 1);
    chk("clr_plain", period_err, 0);

    // Asynchronous reset mid-period
    clk_div_in = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_lock", lock, 0);
    chk("arst_pm", period_meas, 0);
    chk("arst_hm", high_meas, 0);
    chk("arst_errs", {period_err, duty_err, stuck_err, cfg_err}, 0);
    chk("arst_state", dut.state_reg, IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
